// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush handling
// and a saturating counter of load-use bubbles.
module id_ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Flush,
  input  logic            Valid_ID,
  input  logic [4:0]      Rs1_ID,
  input  logic [4:0]      Rs2_ID,
  input  logic [4:0]      Rd_ID,
  input  logic            RegWrite_ID,
  input  logic            MemRead_ID,
  input  logic            MemWrite_ID,
  input  logic            ALUSrc_ID,
  input  logic [3:0]      ALUOp_ID,
  input  logic [XLEN-1:0] PC_ID,
  input  logic [XLEN-1:0] RD1_ID,
  input  logic [XLEN-1:0] RD2_ID,
  input  logic [XLEN-1:0] Imm_ID,
  output logic [4:0]      Rs1_EX,
  output logic [4:0]      Rs2_EX,
  output logic [4:0]      Rd_EX,
  output logic            RegWrite_EX,
  output logic            MemRead_EX,
  output logic            MemWrite_EX,
  output logic            ALUSrc_EX,
  output logic [3:0]      ALUOp_EX,
  output logic [XLEN-1:0] PC_EX,
  output logic [XLEN-1:0] RD1_EX,
  output logic [XLEN-1:0] RD2_EX,
  output logic [XLEN-1:0] Imm_EX,
  output logic            Valid_EX,
  output logic            Stall,
  output logic [CNTW-1:0] StallCount
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  typedef struct packed {
    logic            valid;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
  } ex_t;

  ex_t             ex_d, ex_q;
  logic [CNTW-1:0] stall_cnt_d, stall_cnt_q;
  logic            hazard;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  always_comb begin
    hazard = Valid_ID & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
             ((ex_q.rd == Rs1_ID) | (ex_q.rd == Rs2_ID));
    Stall  = hazard & ~Flush;
  end

  // Next EX contents: flush bubble > stall bubble > load; bubbles are all-zero.
  always_comb begin
    ex_d        = '0;
    stall_cnt_d = stall_cnt_q;
    if (Flush) begin
      ex_d = '0;
    end else if (Stall) begin
      ex_d = '0;
      if (stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + CNTW'(1);
      end
    end else if (Valid_ID) begin
      ex_d.valid     = 1'b1;
      ex_d.rs1       = Rs1_ID;
      ex_d.rs2       = Rs2_ID;
      ex_d.rd        = Rd_ID;
      ex_d.reg_write = RegWrite_ID;
      ex_d.mem_read  = MemRead_ID;
      ex_d.mem_write = MemWrite_ID;
      ex_d.alu_src   = ALUSrc_ID;
      ex_d.alu_op    = ALUOp_ID;
      ex_d.pc        = PC_ID;
      ex_d.rd1       = RD1_ID;
      ex_d.rd2       = RD2_ID;
      ex_d.imm       = Imm_ID;
    end
  end

  // Pipeline register and stall counter, cleared asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Valid_EX    = ex_q.valid;
  assign Rs1_EX      = ex_q.rs1;
  assign Rs2_EX      = ex_q.rs2;
  assign Rd_EX       = ex_q.rd;
  assign RegWrite_EX = ex_q.reg_write;
  assign MemRead_EX  = ex_q.mem_read;
  assign MemWrite_EX = ex_q.mem_write;
  assign ALUSrc_EX   = ex_q.alu_src;
  assign ALUOp_EX    = ex_q.alu_op;
  assign PC_EX       = ex_q.pc;
  assign RD1_EX      = ex_q.rd1;
  assign RD2_EX      = ex_q.rd2;
  assign Imm_EX      = ex_q.imm;
  assign StallCount  = stall_cnt_q;

endmodule
